// File: rtl/ga21_pkg.sv
// ga21_pkg: shared types and widths for the GA21 palette path.
// Used by ga21_pal_dma and ga21_dma_regs.
package ga21_pkg;

  localparam int PAL_AW = 13;
  localparam int PAL_DW = 16;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    RUN,
    FLUSH,
    DONE
  } dma_state_t;

endpackage

// File: rtl/ga21_dma_regs.sv
// ga21_dma_regs: active/shadow DMA parameter sets and pending-start flag.
// Fill parameters exist only when GA21_DMA_FILL_EN is defined.
module ga21_dma_regs
  import ga21_pkg::*;
#(
  parameter int AW = PAL_AW
`ifdef GA21_DMA_FILL_EN
  ,
  parameter int DW = PAL_DW
`endif
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_start,
  input  logic          i_idle,
  input  logic          i_consume,
  input  logic [AW-1:0] i_src,
  input  logic [AW-1:0] i_dst,
  input  logic [AW-1:0] i_len,
`ifdef GA21_DMA_FILL_EN
  input  logic          i_fill,
  input  logic [DW-1:0] i_fval,
  output logic          o_fill,
  output logic [DW-1:0] o_fval,
`endif
  output logic [AW-1:0] o_src,
  output logic [AW-1:0] o_dst,
  output logic [AW-1:0] o_len,
  output logic          o_pend
);

  logic [AW-1:0] r_src;
  logic [AW-1:0] r_dst;
  logic [AW-1:0] r_len;
  logic [AW-1:0] r_sh_src;
  logic [AW-1:0] r_sh_dst;
  logic [AW-1:0] r_sh_len;
  logic          r_pend;
  logic          w_load_port;
  logic          w_load_sh;
  logic          w_to_sh;

  // A start in DONE is loaded straight into the active set.
  assign w_load_port = i_start & (i_idle | i_consume);
  assign w_load_sh   = i_consume & ~i_start;
  assign w_to_sh     = i_start & ~i_idle & ~i_consume;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_src    <= '0;
      r_dst    <= '0;
      r_len    <= '0;
      r_sh_src <= '0;
      r_sh_dst <= '0;
      r_sh_len <= '0;
      r_pend   <= 1'b0;
    end else begin
      if (w_load_port) begin
        r_src <= i_src;
        r_dst <= i_dst;
        r_len <= i_len;
      end else if (w_load_sh) begin
        r_src <= r_sh_src;
        r_dst <= r_sh_dst;
        r_len <= r_sh_len;
      end
      if (w_to_sh) begin
        r_sh_src <= i_src;
        r_sh_dst <= i_dst;
        r_sh_len <= i_len;
        r_pend   <= 1'b1;
      end else if (i_consume) begin
        r_pend <= 1'b0;
      end
    end
  end

`ifdef GA21_DMA_FILL_EN
  logic          r_fill;
  logic [DW-1:0] r_fval;
  logic          r_sh_fill;
  logic [DW-1:0] r_sh_fval;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_fill    <= 1'b0;
      r_fval    <= '0;
      r_sh_fill <= 1'b0;
      r_sh_fval <= '0;
    end else begin
      if (w_load_port) begin
        r_fill <= i_fill;
        r_fval <= i_fval;
      end else if (w_load_sh) begin
        r_fill <= r_sh_fill;
        r_fval <= r_sh_fval;
      end
      if (w_to_sh) begin
        r_sh_fill <= i_fill;
        r_sh_fval <= i_fval;
      end
    end
  end

  assign o_fill = r_fill;
  assign o_fval = r_fval;
`endif

  assign o_src  = r_src;
  assign o_dst  = r_dst;
  assign o_len  = r_len;
  assign o_pend = r_pend;

endmodule

// File: rtl/ga21_pal_dma.sv
// ga21_pal_dma: vblank-gated palette DMA, source buffer -> palette RAM.
// GA21_DMA_FILL_EN adds a constant-fill mode (fill_mode/fill_value).
module ga21_pal_dma
  import ga21_pkg::*;
#(
  parameter int AW = PAL_AW,
  parameter int DW = PAL_DW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] dst_base,
  input  logic [AW-1:0] len,
  input  logic          vblank_in,
`ifdef GA21_DMA_FILL_EN
  input  logic          fill_mode,
  input  logic [DW-1:0] fill_value,
`endif
  output logic          src_rd,
  output logic [AW-1:0] src_addr,
  input  logic [DW-1:0] src_data,
  output logic          ga21_req,
  output logic          ga21_we,
  output logic [AW-1:0] ga21_addr,
  output logic [DW-1:0] pal_dout,
  output logic          dma_busy,
  output logic          done
);

  dma_state_t    r_state;
  dma_state_t    w_next;
  logic [AW-1:0] r_src;
  logic [AW-1:0] r_dst;
  logic [AW-1:0] r_rem;
  logic          r_wv;
  logic [AW-1:0] w_src;
  logic [AW-1:0] w_dst;
  logic [AW-1:0] w_len;
  logic          w_pend;
  logic          w_consume;
  logic          w_fill;
  logic [DW-1:0] w_fval;
  logic          w_run;
  logic          w_act;
  logic          w_we;

  assign w_consume = (r_state == DONE) & (w_pend | start);

  ga21_dma_regs #(
    .AW(AW)
`ifdef GA21_DMA_FILL_EN
    ,
    .DW(DW)
`endif
  ) u_regs (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_start  (start),
    .i_idle   (r_state == IDLE),
    .i_consume(w_consume),
    .i_src    (src_base),
    .i_dst    (dst_base),
    .i_len    (len),
`ifdef GA21_DMA_FILL_EN
    .i_fill   (fill_mode),
    .i_fval   (fill_value),
    .o_fill   (w_fill),
    .o_fval   (w_fval),
`endif
    .o_src    (w_src),
    .o_dst    (w_dst),
    .o_len    (w_len),
    .o_pend   (w_pend)
  );

`ifndef GA21_DMA_FILL_EN
  assign w_fill = 1'b0;
  assign w_fval = '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (start) w_next = ARM;
      ARM:   if (vblank_in) w_next = (w_len == '0) ? DONE : RUN;
      RUN:   if (r_rem == AW'(1)) w_next = FLUSH;
      FLUSH: w_next = DONE;
      DONE:  w_next = (w_pend | start) ? ARM : IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_run = (r_state == RUN);
  assign w_act = w_run | (r_state == FLUSH);
  // Write strobe trails the read by one cycle to meet src_data.
  assign w_we  = r_wv & w_act;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_src <= '0;
      r_dst <= '0;
      r_rem <= '0;
      r_wv  <= 1'b0;
    end else begin
      r_wv <= w_run;
      if (r_state == ARM) begin
        r_src <= w_src;
        r_dst <= w_dst;
        r_rem <= w_len;
      end
      if (w_run) begin
        r_src <= r_src + AW'(1);
        r_rem <= r_rem - AW'(1);
      end
      if (w_we) r_dst <= r_dst + AW'(1);
    end
  end

  always_comb begin
    src_rd    = 1'b0;
    src_addr  = '0;
    ga21_req  = w_act;
    ga21_we   = w_we;
    ga21_addr = '0;
    pal_dout  = '0;
    dma_busy  = (r_state != IDLE);
    done      = (r_state == DONE);
    if (w_run && !w_fill) begin
      src_rd   = 1'b1;
      src_addr = r_src;
    end
    if (w_we) begin
      ga21_addr = r_dst;
      pal_dout  = w_fill ? w_fval : src_data;
    end
  end

endmodule

// File: tb/tb_ga21_pal_dma.sv
// tb_ga21_pal_dma: vector table, corner sequences and random transfers
// checked against a transfer-level model of ga21_pal_dma.
module tb_ga21_pal_dma;

  localparam int AW = 13;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] src_base = '0;
  logic [AW-1:0] dst_base = '0;
  logic [AW-1:0] len = '0;
  logic          vblank_in = 1'b0;
`ifdef GA21_DMA_FILL_EN
  logic          fill_mode = 1'b0;
  logic [DW-1:0] fill_value = '0;
`endif
  logic          src_rd;
  logic [AW-1:0] src_addr;
  logic [DW-1:0] src_data = '0;
  logic          ga21_req;
  logic          ga21_we;
  logic [AW-1:0] ga21_addr;
  logic [DW-1:0] pal_dout;
  logic          dma_busy;
  logic          done;

  ga21_pal_dma #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .src_base  (src_base),
    .dst_base  (dst_base),
    .len       (len),
    .vblank_in (vblank_in),
`ifdef GA21_DMA_FILL_EN
    .fill_mode (fill_mode),
    .fill_value(fill_value),
`endif
    .src_rd    (src_rd),
    .src_addr  (src_addr),
    .src_data  (src_data),
    .ga21_req  (ga21_req),
    .ga21_we   (ga21_we),
    .ga21_addr (ga21_addr),
    .pal_dout  (pal_dout),
    .dma_busy  (dma_busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Source buffer: one-cycle read latency
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) src_data <= src_rd ? mem[src_addr] : '0;

  typedef struct {
    int            c;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t wq[$];
  int  dq[$];
  int  first_rd = -1;
  int  first_req = -1;
  int  n_rd = 0;
  int  n_viol = 0;

  always @(negedge clk) begin
    if (ga21_we) wq.push_back('{cyc, ga21_addr, pal_dout});
    if (done) dq.push_back(cyc);
    if (src_rd) begin
      n_rd++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (ga21_req && first_req < 0) first_req = cyc;
    if ((ga21_we || src_rd) && !ga21_req) n_viol++;
    if (done && !dma_busy) n_viol++;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    wq.delete();
    dq.delete();
    first_rd = -1;
    first_req = -1;
    n_rd = 0;
  endtask

  task automatic drive_start(int s, int d, int l, int fm, int fv);
    src_base = AW'(s);
    dst_base = AW'(d);
    len      = AW'(l);
`ifdef GA21_DMA_FILL_EN
    fill_mode  = (fm != 0);
    fill_value = DW'(fv);
`endif
    start = 1'b1;
  endtask

  // Start pulse with vblank rising vbd cycles later (0: already high)
  task automatic do_start(int s, int d, int l, int vbd, int fm, int fv,
                          output int t);
    @(posedge clk); #1;
    drive_start(s, d, l, fm, fv);
    vblank_in = (vbd == 0);
    t = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    if (vbd > 0) begin
      while (cyc < t + vbd) begin
        @(posedge clk); #1;
      end
      vblank_in = 1'b1;
    end
  endtask

  task automatic wait_done(int t, int n, int bound);
    while (dq.size() < n && cyc < t + bound) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  // Transfer-level model: RUN starts the cycle after vblank is seen in ARM
  task automatic verify(string nm, int s, int d, int l, int t, int vbd,
                        int fv);
    int ready;
    int er;
    int ed;
    logic [AW-1:0] ea;
    logic [AW-1:0] sa;
    logic [DW-1:0] edat;
    ready = (vbd <= 1) ? t + 1 : t + vbd;
    er = ready + 1;
    ed = (l > 0) ? er + l + 1 : ready + 1;
    chk({nm, ":ndone"}, dq.size(), 1);
    if (dq.size() > 0) chk({nm, ":tdone"}, dq[0] - t, ed - t);
    chk({nm, ":nwr"}, wq.size(), l);
    for (int i = 0; i < wq.size() && i < l; i++) begin
      ea = AW'(d + i);
      sa = AW'(s + i);
      edat = (fv >= 0) ? DW'(fv) : mem[sa];
      chk({nm, ":addr"}, wq[i].a, ea);
      chk({nm, ":data"}, wq[i].d, edat);
      chk({nm, ":tw"}, wq[i].c - t, er + 1 + i - t);
    end
    chk({nm, ":nrd"}, n_rd, (fv >= 0) ? 0 : l);
    chk({nm, ":req"}, first_req, (l > 0) ? er : -1);
  endtask

  typedef struct {
    string nm;
    int    s;
    int    d;
    int    l;
    int    vbd;
    int    done_off;
    int    a0;
    int    d0;
    int    alast;
  } vec_t;

  vec_t tbl[6];

  task automatic run_vec(vec_t v);
    int t;
    clear_mon();
    do_start(v.s, v.d, v.l, v.vbd, 0, 0, t);
    wait_done(t, 1, 200);
    if (dq.size() > 0) chk({v.nm, ":tbl_done"}, dq[0] - t, v.done_off);
    else chk({v.nm, ":tbl_done"}, 32'hFFFF_FFFF, v.done_off);
    if (v.l > 0 && wq.size() >= v.l) begin
      chk({v.nm, ":tbl_a0"}, wq[0].a, v.a0);
      chk({v.nm, ":tbl_d0"}, wq[0].d, v.d0);
      chk({v.nm, ":tbl_alast"}, wq[v.l-1].a, v.alast);
    end
    if (v.vbd > 1 && first_rd >= 0)
      chk({v.nm, ":rd_early"}, first_rd >= t + v.vbd, 1);
    verify(v.nm, v.s, v.d, v.l, t, v.vbd, -1);
    vblank_in = 1'b0;
  endtask

  // Second start mid-transfer (or in DONE); dbl adds an overwriting start
  task automatic pend(string nm, int off, bit dbl);
    int t;
    clear_mon();
    do_start('h100, 'h200, 6, 0, 0, 0, t);
    if (dbl) begin
      while (cyc < t + 3) begin
        @(posedge clk); #1;
      end
      drive_start('h120, 'h900, 5, 0, 0);
      @(posedge clk); #1;
      start = 1'b0;
    end
    while (cyc < t + off) begin
      @(posedge clk); #1;
    end
    drive_start('h110, 'h800, 3, 0, 0);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(t, 2, 200);
    chk({nm, ":ndone"}, dq.size(), 2);
    if (dq.size() >= 2) begin
      chk({nm, ":done0"}, dq[0] - t, 9);
      chk({nm, ":done1"}, dq[1] - t, 15);
    end
    chk({nm, ":nwr"}, wq.size(), 9);
    if (wq.size() >= 9) begin
      chk({nm, ":a5"}, wq[5].a, 'h205);
      chk({nm, ":a6"}, wq[6].a, 'h800);
      chk({nm, ":t6"}, wq[6].c - t, 12);
      chk({nm, ":d8"}, wq[8].d, mem['h112]);
    end
    vblank_in = 1'b0;
  endtask

  initial begin
    int t;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    for (int i = 0; i < 64; i++) mem['h100 + i] = DW'('hA000 + i);

    tbl[0] = '{"copy",   'h100, 'h400,  4,  0,  7, 'h400,  'hA000, 'h403};
    tbl[1] = '{"vbwait", 'h100, 'h420,  4, 50, 56, 'h420,  'hA000, 'h423};
    tbl[2] = '{"wrap",   'h100, 'h1FFE, 3,  0,  6, 'h1FFE, 'hA000, 'h0000};
    tbl[3] = '{"len0",   'h100, 'h500,  0,  0,  2, 0,      0,      0};
    tbl[4] = '{"len1",   'h102, 'h010,  1,  0,  4, 'h010,  'hA002, 'h010};
    tbl[5] = '{"vb1",    'h104, 'h030,  2,  1,  5, 'h030,  'hA004, 'h031};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out", {src_rd, src_addr, ga21_req, ga21_we, ga21_addr,
                    pal_dout, dma_busy, done}, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    pend("pend_mid", 4, 1'b0);
    pend("pend_dn", 9, 1'b0);
    pend("pend_dbl", 6, 1'b1);

    clear_mon();
    do_start('h100, 'h600, 8, 0, 0, 0, t);
    while (cyc < t + 5) begin
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid", {src_rd, src_addr, ga21_req, ga21_we, ga21_addr,
                    pal_dout, dma_busy, done}, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    vblank_in = 1'b0;
    repeat (15) @(negedge clk);
    chk("rst_nodone", dq.size(), 0);
    run_vec(tbl[0]);

`ifdef GA21_DMA_FILL_EN
    clear_mon();
    do_start('h100, 'h700, 8, 0, 1, 'h7FFF, t);
    wait_done(t, 1, 200);
    verify("fill", 'h100, 'h700, 8, t, 0, 'h7FFF);
    chk("fill_rd", first_rd, -1);
    vblank_in = 1'b0;
`endif

    for (int k = 0; k < 20; k++) begin
      int s;
      int d;
      int l;
      int vbd;
      s = $urandom_range(0, (1 << AW) - 1);
      d = $urandom_range(0, (1 << AW) - 1);
      l = $urandom_range(0, 24);
      vbd = $urandom_range(0, 4);
      clear_mon();
      do_start(s, d, l, vbd, 0, 0, t);
      wait_done(t, 1, 200);
      verify("rand", s, d, l, t, vbd, -1);
      vblank_in = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    chk("protocol", n_viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ga21_pal_dma.md
# ga21_pal_dma

Palette DMA engine for the GA21 path: on a CPU-issued start it waits for vertical blank, then streams a block of 16-bit words from the shared palette buffer RAM into palette RAM. It sits directly upstream of the palette RAM stage and drives that stage's `ga21_addr`, `ga21_we`, `ga21_req`, write data and `dma_busy` inputs. It also raises a one-cycle completion pulse for the interrupt controller.

## Interface
Parameters:
- `AW`, 13, address width of source buffer and palette RAM, in words
- `DW`, 16, data width

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock; all state updates on rising edge
- `reset_n`  in  1  synchronous active-low reset
- `start`  in  1  one-cycle pulse from CPU register write; latches `src_base`, `dst_base` and `len`
- `src_base`  in  AW  first source word address
- `dst_base`  in  AW  first palette RAM word address
- `len`  in  AW  word count; 0 means no transfer
- `vblank_in`  in  1  active-high vertical blank
- `src_rd`  out  1  source read strobe
- `src_addr`  out  AW  source read address
- `src_data`  in  DW  source data, valid the cycle after `src_rd`
- `ga21_req`  out  1  palette RAM bus request to the palette stage
- `ga21_we`  out  1  palette RAM write enable
- `ga21_addr`  out  AW  palette RAM write address
- `pal_dout`  out  DW  palette RAM write data
- `dma_busy`  out  1  transfer armed or running
- `done`  out  1  one-cycle completion pulse
- `fill_mode`, `fill_value`  in  1 / DW  present only with `GA21_DMA_FILL_EN`

## Operation
- States: IDLE, ARM, RUN, FLUSH, DONE.
- IDLE: on `start`, latch the parameters and go to ARM.
- ARM: stay while `vblank_in`=0. When `vblank_in`=1 (level-sensitive, so an already-active vblank counts), go to RUN. If `len`=0, go to DONE instead.
- RUN: each cycle, assert `src_rd` with `src_addr` = src pointer, then increment the pointer.
  - Write pipeline: the word read in cycle n is written in cycle n+1 (`ga21_we`=1, `ga21_addr` = dst pointer, `pal_dout` = `src_data`), and the dst pointer increments after each write.
  - After issuing read number `len`, go to FLUSH.
- FLUSH: perform the final write, then go to DONE.
- DONE: pulse `done` for one cycle, then go to IDLE. If a start is pending, go to ARM instead and consume it.
- Start pending: a `start` seen in any non-IDLE state sets a one-deep pending flag and captures the new parameters into a shadow set. A second `start` overwrites the shadow set.
- Pointers: src and dst pointers wrap modulo 2^AW, with no error on wrap.
- `vblank_in` falling mid-transfer does not abort the transfer.
- Data path: writes use `src_data` directly from the source port. The only registers in the path are the pointers and pipeline valid bits.

## Timing
- Reset: every output is 0, state is IDLE, and the pending flag is clear. Reset asserted mid-transfer abandons the transfer immediately; no `done` pulse is produced.
- `start` at cycle t with vblank already high:
  - ARM at t+1, RUN at t+2.
  - First `src_rd` at t+2, first `ga21_we` at t+3.
  - Last write at t+len+2, `done` at t+len+3.
- `dma_busy`: 1 in ARM, RUN, FLUSH and DONE; 0 in IDLE.
- `ga21_req`: 1 in RUN and FLUSH only. It is high one cycle before the first write.
- `ga21_we`: never asserted outside RUN and FLUSH. Steady-state throughput is one word per clock.
- `len`=0: ARM goes to DONE and `done` pulses. No `src_rd`, no `ga21_we`, and `ga21_req` stays 0.
- `start` in the same cycle as the DONE state: it becomes pending and wins. The next state is ARM.

## Configuration
- `GA21_DMA_FILL_EN` defined: adds the `fill_mode` and `fill_value` ports, latched at `start` alongside the other parameters.
  - With `fill_mode`=1, `src_rd` stays 0 and `pal_dout` = `fill_value`.
  - Write timing is identical to copy mode.
- Undefined: the ports are absent and only copy mode exists.

## Structure
- Shared package `ga21_pkg`: state enum `dma_state_t` (IDLE, ARM, RUN, FLUSH, DONE), plus `PAL_AW`=13 and `PAL_DW`=16.
- Sub-module `ga21_dma_regs`: holds the active and shadow parameter sets and the pending flag. Everything else stays in the top FSM.

## Test plan
- Copy run: vblank=1, `src_base`=0x0100, `dst_base`=0x0400, `len`=4, source holding 0xA000+i → writes 0xA000..0xA003 to 0x0400..0x0403 on cycles t+3..t+6, `done` at t+7.
- Wait for vblank: start with vblank=0, raise vblank 50 cycles later → no `src_rd` or `ga21_req` before then; first write 2 cycles after vblank rises.
- Wrap and zero length:
  - `dst_base`=0x1FFE, `len`=3 → writes to 0x1FFE, 0x1FFF, 0x0000.
  - `len`=0 → `done` 2 cycles after start with zero writes.
- Pending start: second start with `dst_base`=0x0800 mid-transfer → first transfer completes, `done` pulses, ARM follows immediately, and the second block lands at 0x0800.
- Reset mid-RUN: drop `reset_n` after the second write → next cycle all outputs are 0, no `done`, and a fresh start works normally.
- Fill mode (`GA21_DMA_FILL_EN`): `fill_mode`=1, `fill_value`=0x7FFF, `len`=8 → eight writes of 0x7FFF and `src_rd` never high.
